tri_side_loader: RTL

- Upstream feeder and collector for the triangle-condition checker (tgc2).
- Accepts side lengths one byte at a time over a valid/ready stream and assembles them into an a/b/c triple. The triple is presented to an internal triangle evaluation equivalent to tgc2, and the registered result is returned over a valid/ready handshake.
- Keeps saturating statistics of how many triples were checked and how many formed triangles; used by the week7 display path.

---
 rtl/tri_side_loader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/tri_side_loader.sv
// Byte-serial a/b/c loader feeding a triangle-condition evaluation, with a
// valid/ready result port and saturating statistics counters.
module tri_side_loader #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             res_ready,
    output logic             res_valid,
    output logic             Q,
    output logic [W-1:0]     a,
    output logic [W-1:0]     b,
    output logic [W-1:0]     c,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] tri_cnt
);

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        LOAD_C,
        EVAL,
        RESULT
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, c_q, c_d;
    logic             q_q, q_d;
    logic             rv_q, rv_d;
    logic [CNT_W-1:0] total_q, total_d, tcnt_q, tcnt_d;

    // One extra bit on each sum keeps e.g. 255+255 from wrapping.
    logic [W:0] sum_ab, sum_bc, sum_ac;
    logic       is_triangle;

    always_comb begin
        sum_ab      = {1'b0, a_q} + {1'b0, b_q};
        sum_bc      = {1'b0, b_q} + {1'b0, c_q};
        sum_ac      = {1'b0, a_q} + {1'b0, c_q};
        is_triangle = (sum_ab > {1'b0, c_q}) &&
                      (sum_bc > {1'b0, a_q}) &&
                      (sum_ac > {1'b0, b_q});
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        q_d       = q_q;
        rv_d      = rv_q;
        total_d   = total_q;
        tcnt_d    = tcnt_q;
        din_ready = 1'b0;

        case (state_q)
            LOAD_A: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    a_d     = din;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    b_d     = din;
                    state_d = LOAD_C;
                end
            end
            LOAD_C: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    c_d     = din;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                q_d     = is_triangle;
                rv_d    = 1'b1;
                state_d = RESULT;
                if (total_q != '1) total_d = total_q + 1'b1;
                if (is_triangle && (tcnt_q != '1)) tcnt_d = tcnt_q + 1'b1;
            end
            RESULT: begin
                if (res_ready) begin
                    rv_d    = 1'b0;
                    state_d = LOAD_A;
                end
            end
            default: state_d = LOAD_A;
        endcase

        // Clear overrides a same-cycle EVAL increment.
        if (clr_stats) begin
            total_d = '0;
            tcnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            q_q     <= 1'b0;
            rv_q    <= 1'b0;
            total_q <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            q_q     <= q_d;
            rv_q    <= rv_d;
            total_q <= total_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign res_valid = rv_q;
    assign Q         = q_q;
    assign a         = a_q;
    assign b         = b_q;
    assign c         = c_q;
    assign total_cnt = total_q;
    assign tri_cnt   = tcnt_q;

endmodule
